// File: rtl/tlul_pkg.sv
// Shared TL-UL opcodes, sizes and master FSM state for tlul_simple_master.
package tlul_pkg;

  localparam int unsigned TL_DW = 32;
  localparam int unsigned TL_MW = 4;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  // Every request is a single 32-bit word: log2(4 bytes).
  localparam logic [3:0] TL_SIZE_WORD   = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_A_SEND = 2'd1,
    ST_D_WAIT = 2'd2,
    ST_RESP   = 2'd3
  } master_state_e;

endpackage

// File: rtl/tlul_simple_master_if.sv
// TL-UL A/D channel bundle between an initiator (master) and a responder (slave).
interface tlul_simple_master_if #(
  parameter int unsigned TL_RS = 4,
  parameter int unsigned AW    = 32
) ();

  logic [2:0]       tlm_a_opcode;
  logic [2:0]       tlm_a_param;
  logic [3:0]       tlm_a_size;
  logic [TL_RS-1:0] tlm_a_source;
  logic [AW-1:0]    tlm_a_address;
  logic [3:0]       tlm_a_mask;
  logic [31:0]      tlm_a_data;
  logic             tlm_a_corrupt;
  logic             tlm_a_valid;
  logic             tlm_a_ready;

  logic [2:0]       tlm_d_opcode;
  logic [1:0]       tlm_d_param;
  logic [3:0]       tlm_d_size;
  logic [TL_RS-1:0] tlm_d_source;
  logic             tlm_d_denied;
  logic [31:0]      tlm_d_data;
  logic             tlm_d_corrupt;
  logic             tlm_d_valid;
  logic             tlm_d_ready;

  modport master (
    output tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_source, tlm_a_address,
           tlm_a_mask, tlm_a_data, tlm_a_corrupt, tlm_a_valid, tlm_d_ready,
    input  tlm_a_ready, tlm_d_opcode, tlm_d_param, tlm_d_size, tlm_d_source,
           tlm_d_denied, tlm_d_data, tlm_d_corrupt, tlm_d_valid
  );

  modport slave (
    input  tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_source, tlm_a_address,
           tlm_a_mask, tlm_a_data, tlm_a_corrupt, tlm_a_valid, tlm_d_ready,
    output tlm_a_ready, tlm_d_opcode, tlm_d_param, tlm_d_size, tlm_d_source,
           tlm_d_denied, tlm_d_data, tlm_d_corrupt, tlm_d_valid
  );

endinterface

// File: rtl/tlul_timeout_ctr.sv
// D-channel wait counter: cleared by load, counts while enabled, flags LIMIT-1.
module tlul_timeout_ctr #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_c = enable && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/tlul_simple_master.sv
// Single-outstanding TL-UL initiator bridging a cmd/rsp handshake to the A/D channels.
// Optional D-wait timeout compiled in with TLUL_MASTER_TIMEOUT_EN.
module tlul_simple_master
  import tlul_pkg::*;
#(
  parameter int unsigned TL_RS          = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned SOURCE_ID      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 tlm_clock_i,
  input  logic                 tlm_reset_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [AW-1:0]        cmd_addr_i,
  input  logic [TL_DW-1:0]     cmd_wdata_i,
  input  logic [TL_MW-1:0]     cmd_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [TL_DW-1:0]     rsp_rdata_o,
  output logic                 rsp_err_o,
  tlul_simple_master_if.master tl
);

  master_state_e    state_q, state_d;
  logic             cmd_ready_q, a_valid_q, d_ready_q, rsp_valid_q;
  logic [2:0]       a_opcode_q, a_opcode_d;
  logic [3:0]       a_size_q, a_size_d;
  logic [TL_RS-1:0] a_source_q, a_source_d;
  logic [AW-1:0]    a_address_q, a_address_d;
  logic [TL_MW-1:0] a_mask_q, a_mask_d;
  logic [TL_DW-1:0] a_data_q, a_data_d;
  logic             is_write_q, is_write_d;
  logic [TL_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             d_match, d_err, to_expire;
  logic             unused_bits;

  assign d_match = tl.tlm_d_valid && d_ready_q && (tl.tlm_d_source == TL_RS'(SOURCE_ID));
  assign d_err   = tl.tlm_d_denied || tl.tlm_d_corrupt ||
                   (is_write_q ? (tl.tlm_d_opcode != TL_ACK) : (tl.tlm_d_opcode != TL_ACK_DATA));

`ifdef TLUL_MASTER_TIMEOUT_EN
  logic a_fire;
  assign a_fire = (state_q == ST_A_SEND) && tl.tlm_a_ready;

  tlul_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (tlm_clock_i),
    .rst      (tlm_reset_i),
    .load     (a_fire),
    .enable   (state_q == ST_D_WAIT),
    .expire_c (to_expire)
  );
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_expire = 1'b0;
`endif

  // State, request and response registers; handshake outputs are flopped from next state.
  always_ff @(posedge tlm_clock_i) begin
    if (tlm_reset_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      a_valid_q   <= 1'b0;
      d_ready_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      is_write_q  <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      a_valid_q   <= (state_d == ST_A_SEND);
      d_ready_q   <= (state_d != ST_RESP);
      rsp_valid_q <= (state_d == ST_RESP);
      a_opcode_q  <= a_opcode_d;
      a_size_q    <= a_size_d;
      a_source_q  <= a_source_d;
      a_address_q <= a_address_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      is_write_q  <= is_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and register-update logic; D beats outside D_WAIT are simply accepted and dropped.
  always_comb begin
    state_d     = state_q;
    a_opcode_d  = a_opcode_q;
    a_size_d    = a_size_q;
    a_source_d  = a_source_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    is_write_d  = is_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          is_write_d = cmd_write_i;
          if (cmd_write_i && (cmd_be_i == '0)) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            state_d     = ST_RESP;
          end else begin
            a_opcode_d  = !cmd_write_i ? TL_GET :
                          ((cmd_be_i == 4'hF) ? TL_PUT_FULL : TL_PUT_PARTIAL);
            a_size_d    = TL_SIZE_WORD;
            a_source_d  = TL_RS'(SOURCE_ID);
            a_address_d = {cmd_addr_i[AW-1:2], 2'b00};
            a_mask_d    = cmd_write_i ? cmd_be_i : 4'hF;
            a_data_d    = cmd_write_i ? cmd_wdata_i : '0;
            state_d     = ST_A_SEND;
          end
        end
      end
      ST_A_SEND: begin
        if (tl.tlm_a_ready) state_d = ST_D_WAIT;
      end
      ST_D_WAIT: begin
        if (d_match) begin
          rsp_err_d   = d_err;
          rsp_rdata_d = (d_err || is_write_q) ? '0 : tl.tlm_d_data;
          state_d     = ST_RESP;
        end else if (to_expire) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_err_o        = rsp_err_q;

  assign tl.tlm_a_opcode  = a_opcode_q;
  assign tl.tlm_a_param   = 3'd0;
  assign tl.tlm_a_size    = a_size_q;
  assign tl.tlm_a_source  = a_source_q;
  assign tl.tlm_a_address = a_address_q;
  assign tl.tlm_a_mask    = a_mask_q;
  assign tl.tlm_a_data    = a_data_q;
  assign tl.tlm_a_corrupt = 1'b0;
  assign tl.tlm_a_valid   = a_valid_q;
  assign tl.tlm_d_ready   = d_ready_q;

  assign unused_bits = ^{tl.tlm_d_param, tl.tlm_d_size, cmd_addr_i[1:0]};

endmodule

// File: tb/tb_tlul_simple_master.sv
// Directed bench for tlul_simple_master; the timeout steps follow TLUL_MASTER_TIMEOUT_EN.
module tb_tlul_simple_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  tlul_simple_master_if #(.TL_RS(4), .AW(32)) tl ();

  tlul_simple_master #(
    .TL_RS          (4),
    .AW             (32),
    .SOURCE_ID      (5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .tlm_clock_i (clk),
    .tlm_reset_i (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_be_i    (cmd_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .tl          (tl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_be    = be;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [2:0] op, input logic [3:0] src, input logic den,
                         input logic cor, input logic [31:0] data);
    tl.tlm_d_opcode  = op;
    tl.tlm_d_source  = src;
    tl.tlm_d_denied  = den;
    tl.tlm_d_corrupt = cor;
    tl.tlm_d_data    = data;
    tl.tlm_d_valid   = 1'b1;
    tick();
    tl.tlm_d_valid   = 1'b0;
  endtask

  task automatic finish_rsp(input logic [31:0] rd, input logic er);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, rd);
    chk("rsp_err", rsp_err, er);
    chk("d_ready_in_resp", tl.tlm_d_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    rsp_ready = 1'b0;
    tl.tlm_a_ready = 1'b1;
    tl.tlm_d_valid = 1'b0; tl.tlm_d_opcode = '0; tl.tlm_d_param = '0; tl.tlm_d_size = '0;
    tl.tlm_d_source = '0; tl.tlm_d_denied = 1'b0; tl.tlm_d_data = '0; tl.tlm_d_corrupt = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_a_valid", tl.tlm_a_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_d_ready", tl.tlm_d_ready, 1);
    chk("rst_a_opcode", tl.tlm_a_opcode, 0);
    chk("rst_a_address", tl.tlm_a_address, 0);
    chk("rst_a_mask", tl.tlm_a_mask, 0);

    // Read 0x4, AckData 0xA5A5 one cycle after A
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    chk("rd_a_valid_c1", tl.tlm_a_valid, 1);
    chk("rd_a_opcode", tl.tlm_a_opcode, 3'd4);
    chk("rd_a_mask", tl.tlm_a_mask, 4'hF);
    chk("rd_a_size", tl.tlm_a_size, 4'd2);
    chk("rd_a_address", tl.tlm_a_address, 32'h4);
    chk("rd_a_source", tl.tlm_a_source, 4'd5);
    chk("rd_a_param", tl.tlm_a_param, 0);
    chk("rd_cmd_ready_busy", cmd_ready, 0);
    tick();
    chk("rd_a_valid_c2", tl.tlm_a_valid, 0);
    chk("rd_rsp_valid_c2", rsp_valid, 0);
    respond(3'd1, 4'd5, 1'b0, 1'b0, 32'h0000_A5A5);
    finish_rsp(32'h0000_A5A5, 1'b0);

    // Partial write, address low bits dropped
    issue(1'b1, 32'h0000_000B, 32'h0000_1234, 4'b0011);
    chk("wrp_a_opcode", tl.tlm_a_opcode, 3'd1);
    chk("wrp_a_mask", tl.tlm_a_mask, 4'h3);
    chk("wrp_a_data", tl.tlm_a_data, 32'h1234);
    chk("wrp_a_address", tl.tlm_a_address, 32'h8);
    chk("wrp_a_size", tl.tlm_a_size, 4'd2);
    tick();
    respond(3'd0, 4'd5, 1'b0, 1'b0, 32'hFFFF_FFFF);
    finish_rsp(32'h0, 1'b0);

    // Full write
    issue(1'b1, 32'h0000_0008, 32'h0000_1234, 4'hF);
    chk("wrf_a_opcode", tl.tlm_a_opcode, 3'd0);
    chk("wrf_a_mask", tl.tlm_a_mask, 4'hF);
    tick();
    respond(3'd0, 4'd5, 1'b0, 1'b0, 32'h0);
    finish_rsp(32'h0, 1'b0);

    // A-channel backpressure then response backpressure
    tl.tlm_a_ready = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_a_valid", tl.tlm_a_valid, 1);
      chk("bp_a_address", tl.tlm_a_address, 32'h10);
      chk("bp_a_opcode", tl.tlm_a_opcode, 3'd4);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    tl.tlm_a_ready = 1'b1;
    chk("bp_a_valid_last", tl.tlm_a_valid, 1);
    tick();
    chk("bp_a_valid_dropped", tl.tlm_a_valid, 0);
    respond(3'd1, 4'd5, 1'b0, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_rsp_err", rsp_err, 0);
      chk("bp_cmd_ready_resp", cmd_ready, 0);
      tick();
    end
    finish_rsp(32'hDEAD_BEEF, 1'b0);

    // Write with no byte enables: straight to response
    issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h0);
    chk("be0_a_valid", tl.tlm_a_valid, 0);
    finish_rsp(32'h0, 1'b0);

    // Denied read
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    tick();
    respond(3'd1, 4'd5, 1'b1, 1'b0, 32'h0000_0055);
    finish_rsp(32'h0, 1'b1);

    // Wrong-source beat dropped, then matching beat with wrong opcode for a read
    issue(1'b0, 32'h0000_0034, 32'h0, 4'h0);
    tick();
    respond(3'd1, 4'd0, 1'b0, 1'b0, 32'h0000_0077);
    chk("ws_rsp_valid", rsp_valid, 0);
    chk("ws_d_ready", tl.tlm_d_ready, 1);
    respond(3'd0, 4'd5, 1'b0, 1'b0, 32'h0000_0088);
    finish_rsp(32'h0, 1'b1);

    // Corrupt write ack, then write answered with AckData
    issue(1'b1, 32'h0000_0040, 32'h1, 4'hF);
    tick();
    respond(3'd0, 4'd5, 1'b0, 1'b1, 32'h0);
    finish_rsp(32'h0, 1'b1);
    issue(1'b1, 32'h0000_0040, 32'h1, 4'h1);
    tick();
    respond(3'd1, 4'd5, 1'b0, 1'b0, 32'h0);
    finish_rsp(32'h0, 1'b1);

    // Reset in D_WAIT; late beat drained in IDLE
    issue(1'b0, 32'h0000_0044, 32'h0, 4'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_a_valid", tl.tlm_a_valid, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    tick();
    respond(3'd1, 4'd5, 1'b0, 1'b0, 32'h0000_0BAD);
    chk("mr_rsp_valid_late", rsp_valid, 0);
    chk("mr_cmd_ready_late", cmd_ready, 1);
    tick();
    chk("mr_rsp_valid_later", rsp_valid, 0);
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    tick();
    respond(3'd1, 4'd5, 1'b0, 1'b0, 32'h0000_0001);
    finish_rsp(32'h0000_0001, 1'b0);

`ifdef TLUL_MASTER_TIMEOUT_EN
    // No D beat: error response 8 cycles after entering D_WAIT
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_rsp_valid_wait", rsp_valid, 0);
      tick();
    end
    finish_rsp(32'h0, 1'b1);

    // Matching beat on the expiry cycle wins
    issue(1'b0, 32'h0000_0054, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("to_prio_rsp_valid", rsp_valid, 0);
    respond(3'd1, 4'd5, 1'b0, 1'b0, 32'h0000_0099);
    finish_rsp(32'h0000_0099, 1'b0);
`else
    // Without the timeout, D_WAIT holds indefinitely
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("nto_rsp_valid_wait", rsp_valid, 0);
      tick();
    end
    respond(3'd1, 4'd5, 1'b0, 1'b0, 32'h0000_0099);
    finish_rsp(32'h0000_0099, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
